// File: rtl/alu_muldiv_ctrl_if.sv
// EX-stage bundle between the pipeline and the ALU control / multiply-divide unit.
// The pipeline side drives the master modport; the ALU control block sits on slave.
interface alu_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             flush_i;
  logic [3:0]       aluOp;
  logic [5:0]       func;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [3:0]       aluController;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic             illegal_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output valid_i, flush_i, aluOp, func, srcA, srcB,
    input  aluController, stall_o, busy_o, done_o, illegal_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, flush_i, aluOp, func, srcA, srcB,
    output aluController, stall_o, busy_o, done_o, illegal_o, hi_o, lo_o
  );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control decode plus an iterative multiply/divide engine that owns HI/LO.
// The engine runs on magnitudes and applies MIPS sign rules in a single fixup cycle.
module alu_muldiv_ctrl #(
  parameter int WIDTH  = 32,
  parameter bit EN_DIV = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  alu_muldiv_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_isDiv;
  logic             r_signA;
  logic             r_signB;
  logic             r_divZero;
  logic [WIDTH-1:0] r_origA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic             w_rType;
  logic             w_mult;
  logic             w_div;
  logic             w_md;
  logic             w_hilo;
  logic             w_mthi;
  logic             w_mtlo;
  logic             w_issue;
  logic             w_busy;
  logic             w_illegal;
  logic             w_start;
  logic             w_negA;
  logic             w_negB;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [3:0]       w_aluCtrl;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic             w_divGe;
  logic [WIDTH-1:0] w_divDiff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0] w_quoFix;
  logic [WIDTH-1:0] w_remFix;

  always_comb begin
    w_aluCtrl = 4'b0000;
    case (bus.aluOp)
      4'b0000: w_aluCtrl = 4'b0000;
      4'b0001: w_aluCtrl = 4'b0001;
      4'b0010: begin
        case (bus.func)
          F_ADD:   w_aluCtrl = 4'b0000;
          F_SUB:   w_aluCtrl = 4'b0001;
          F_SLT:   w_aluCtrl = 4'b0011;
          F_AND:   w_aluCtrl = 4'b0100;
          F_OR:    w_aluCtrl = 4'b0101;
          F_MFHI:  w_aluCtrl = 4'b0110;
          F_MFLO:  w_aluCtrl = 4'b0111;
          default: w_aluCtrl = 4'b0000;
        endcase
      end
      4'b0011: w_aluCtrl = (bus.func == 6'b000010) ? 4'b0010 : 4'b0000;
      default: w_aluCtrl = 4'b0000;
    endcase
  end

  assign w_rType   = (bus.aluOp == 4'b0010);
  assign w_mult    = w_rType & ((bus.func == F_MULT) | (bus.func == F_MULTU));
  assign w_div     = w_rType & ((bus.func == F_DIV) | (bus.func == F_DIVU));
  assign w_md      = w_mult | w_div;
  assign w_mthi    = w_rType & (bus.func == F_MTHI);
  assign w_mtlo    = w_rType & (bus.func == F_MTLO);
  assign w_hilo    = w_mthi | w_mtlo | (w_rType & ((bus.func == F_MFHI) | (bus.func == F_MFLO)));
  assign w_issue   = bus.valid_i & ~bus.flush_i;
  assign w_busy    = (r_state != S_IDLE);
  assign w_illegal = w_issue & ~EN_DIV & w_div;
  assign w_start   = w_issue & w_md & ~w_illegal & ~w_busy;

  // func bit 0 clear marks the signed variants (MULT, DIV)
  assign w_negA = ~bus.func[0] & bus.srcA[WIDTH-1];
  assign w_negB = ~bus.func[0] & bus.srcB[WIDTH-1];
  assign w_absA = w_negA ? -bus.srcA : bus.srcA;
  assign w_absB = w_negB ? -bus.srcB : bus.srcB;

  // One shift-add or restoring-subtract step; r_q holds multiplier / dividend bits
  assign w_mulSum   = {1'b0, r_r} + (r_q[0] ? {1'b0, r_opB} : '0);
  assign w_divShift = {r_r, r_q[WIDTH-1]};
  assign w_divGe    = (w_divShift >= {1'b0, r_opB});
  assign w_divDiff  = w_divShift[WIDTH-1:0] - r_opB;

  assign w_prod    = {r_r, r_q};
  assign w_prodFix = (r_signA ^ r_signB) ? -w_prod : w_prod;
  assign w_quoFix  = (r_signA ^ r_signB) ? -r_q : r_q;
  assign w_remFix  = r_signA ? -r_r : r_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_cnt   <= CW'(WIDTH);
          end else if (w_issue & w_mthi) begin
            r_hi <= bus.srcA;
          end else if (w_issue & w_mtlo) begin
            r_lo <= bus.srcA;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!r_isDiv) begin
            r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFix[WIDTH-1:0];
          end else if (r_divZero) begin
            r_hi <= r_origA;
            r_lo <= '1;
          end else begin
            r_hi <= w_remFix;
            r_lo <= w_quoFix;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand/iteration registers need no reset: always loaded on start before use
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_isDiv   <= w_div;
      r_signA   <= w_negA;
      r_signB   <= w_negB;
      r_divZero <= (bus.srcB == '0);
      r_origA   <= bus.srcA;
      r_opB     <= w_absB;
      r_q       <= w_absA;
      r_r       <= '0;
    end else if (r_state == S_RUN) begin
      if (r_isDiv) begin
        r_r <= w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
        r_q <= {r_q[WIDTH-2:0], w_divGe};
      end else begin
        r_r <= w_mulSum[WIDTH:1];
        r_q <= {w_mulSum[0], r_q[WIDTH-1:1]};
      end
    end
  end

  assign bus.aluController = w_aluCtrl;
  assign bus.stall_o       = w_issue & w_busy & (w_md | w_hilo);
  assign bus.busy_o        = w_busy;
  assign bus.done_o        = r_done;
  assign bus.illegal_o     = w_illegal;
  assign bus.hi_o          = r_hi;
  assign bus.lo_o          = r_lo;

endmodule

// File: doc/alu_muldiv_ctrl.md
Name: alu_muldiv_ctrl

Overview:
Next-generation EX-stage ALU control unit for the 5-stage MIPS32 pipeline.
- Keeps the combinational aluOp/func → aluController decode and extends it with AND, OR, MFHI and MFLO.
- Adds a parametrised iterative multiply/divide engine with HI/LO registers.
- MULT/MULTU/DIV/DIVU issue and retire asynchronously to the pipeline. The pipeline stalls only when an instruction needs HI/LO or the engine while the engine is busy.

Parameters:
WIDTH, 32, datapath/operand width; sets iteration count.
EN_DIV, 1, 1 = DIV/DIVU supported; 0 = DIV/DIVU flagged illegal and never started.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
valid_i  in  1  EX-stage instruction valid.
flush_i  in  1  EX-stage instruction squashed this cycle.
aluOp  in  4  ALU instruction class from main decoder.
func  in  6  R-type function field.
srcA  in  WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO source).
srcB  in  WIDTH  rt operand (divisor/multiplier).
aluController  out  4  ALU control code.
stall_o  out  1  hold IF/ID/EX; re-present the same instruction next cycle.
busy_o  out  1  engine running.
done_o  out  1  one-cycle pulse after HI/LO update.
illegal_o  out  1  unsupported MD op presented.
hi_o  out  WIDTH  HI register.
lo_o  out  WIDTH  LO register.

Behaviour:
- Decode, combinational, independent of state and of valid_i:
  - aluOp 0000→0000; aluOp 0001→0001.
  - aluOp 0010 by func: 100000→0000, 100010→0001, 101010→0011, 100100→0100, 100101→0101, 010000(MFHI)→0110, 010010(MFLO)→0111, anything else→0000.
  - aluOp 0011: func 000010→0010, else 0000.
  - Any other aluOp→0000.
- MD class (aluOp 0010 only): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. HI/LO class: MFHI, MFLO, MTHI 010001, MTLO 010011.
- Gating: issue = valid_i & ~flush_i.
- Stall: stall_o = issue & busy_o & (MD | HI/LO class), combinational. All other instructions pass while busy.
- Illegal: illegal_o = issue & EN_DIV==0 & func∈{DIV, DIVU} & aluOp==0010. No start, no HI/LO change.
- FSM states IDLE, RUN, FIX. Reset → IDLE.
- IDLE:
  - issue & MD & ~illegal at edge T: latch |srcA|, |srcB| (signed ops) or raw values (unsigned), the sign flags, and a copy of srcA. Set counter=WIDTH. Next state RUN; busy_o=1 from T.
  - issue & MTHI: hi_o←srcA at edge. issue & MTLO: lo_o←srcA at edge.
- RUN:
  - One bit per edge. Multiply: shift-add, 2·WIDTH product. Divide: restoring, quotient/remainder.
  - Counter decrements; after WIDTH RUN edges → FIX.
- FIX edge (T+WIDTH+1):
  - Apply sign fixup. MULT: negate the product if signs differ. DIV: quotient negated if sA^sB; remainder takes the sign of the dividend.
  - Write HI←product[2W-1:W] / remainder, LO←product[W-1:0] / quotient.
  - busy_o←0, done_o←1 for exactly one cycle, state→IDLE.
  - Latency: HI/LO valid in cycle T+WIDTH+2; busy_o high WIDTH+1 cycles.
- Divide by zero (DIV or DIVU): same latency, LO=all-ones, HI=original srcA, no sign fixup.
- DIV of most-negative by −1: LO=most-negative (wrap), HI=0.
- flush_i only blocks acceptance in the issue cycle; an accepted operation always completes.
- Held MD/HI-LO instruction: accepted on the first cycle busy_o=0, which is the cycle after the FIX edge.
- Reset (any state, including mid-RUN): next edge → IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter=0.
- stall_o, illegal_o and aluController are combinational and have no reset value.

Test Plan:
- Reset asserted 2 cycles then released → hi_o=0, lo_o=0, busy_o=0, done_o=0; full aluOp×func sweep matches decode table (e.g. 0010/100101→0101, 0011/000010→0010, 0101/xx→0000).
- MULT srcA=0xFFFFFFFD, srcB=7 → busy_o high 33 cycles, done_o pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT then ADD next cycle → no stall, aluController=0000; MFLO 3 cycles later → stall_o high until busy_o falls, then aluController=0111 with the correct lo_o; MTHI issued while busy → stalled, written after completion.
- MULT presented with flush_i=1 → no start, busy_o stays 0; EN_DIV=0 build with DIV → illegal_o=1, HI/LO unchanged.
- rst_n low at RUN cycle 10 → next cycle busy_o=0, hi_o=lo_o=0, no done_o pulse; new MULTU 3×5 then gives LO=15, HI=0.
